// File: rtl/ins_cache_r32i.sv
// Direct-mapped read-only RV32I instruction cache; refills a whole line over a req/ack port.
// Latency: hits are combinational from ProgAddr; a miss stalls at least lineWords+1 cycles.
// Backpressure: MemReq/MemAddr hold until MemAck; InsCacheStall freezes the PC meanwhile.
module ins_cache_r32i #(
   parameter int dataW     = 32,
   parameter int lineWords = 4,
   parameter int numLines  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [dataW-1:0] ProgAddr,
   input  logic             Flush,
   output logic [dataW-1:0] Instruction,
   output logic             InsCacheStall,
   output logic             MemReq,
   output logic [dataW-1:0] MemAddr,
   input  logic             MemAck,
   input  logic [dataW-1:0] MemData
);

   localparam int OFFW = $clog2(lineWords);
   localparam int IDXW = $clog2(numLines);
   localparam int TAGW = dataW - OFFW - IDXW - 2;
   localparam logic [dataW-1:0] NOP = dataW'(32'h0000_0013);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t              state_q;
   logic [OFFW-1:0]     cnt_q;
   logic [TAGW-1:0]     base_tag_q;
   logic [IDXW-1:0]     base_idx_q;
   logic                MemReq_q;
   logic [dataW-1:0]    MemAddr_q;
   logic [numLines-1:0] valid_q;
   logic [numLines-1:0] valid_d;

   // Line storage: no reset, a line is only trusted once its valid bit is set.
   logic [dataW-1:0]    data_q [numLines][lineWords];
   logic [TAGW-1:0]     tag_q  [numLines];

   logic [OFFW-1:0]     req_off;
   logic [IDXW-1:0]     req_idx;
   logic [TAGW-1:0]     req_tag;
   logic                hit;
   logic                last_word;
   logic [numLines-1:0] refill_mask;
   logic                unused_addr_bits;

   assign req_off          = ProgAddr[OFFW+1:2];
   assign req_idx          = ProgAddr[OFFW+IDXW+1:OFFW+2];
   assign req_tag          = ProgAddr[dataW-1:OFFW+IDXW+2];
   assign unused_addr_bits = ^ProgAddr[1:0];

   assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign last_word   = (cnt_q == OFFW'(lineWords - 1));
   assign refill_mask = numLines'(1) << base_idx_q;

   // Next valid bits: flush wipes everything except an in-flight refill, whose
   // line becomes valid when its last word is acknowledged.
   always_comb begin
      valid_d = valid_q;
      if (state_q == IDLE) begin
         if (Flush) valid_d = '0;
      end else begin
         if (Flush) valid_d = valid_q & refill_mask;
         if (MemAck && last_word) valid_d = valid_d | refill_mask;
      end
   end

   // Miss handling FSM: latch the line base on a miss, step through the words on each ack.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         base_tag_q <= '0;
         base_idx_q <= '0;
         MemReq_q   <= 1'b0;
         MemAddr_q  <= '0;
         valid_q    <= '0;
      end else begin
         valid_q <= valid_d;
         case (state_q)
            IDLE: begin
               if (!Flush && !hit) begin
                  state_q    <= REFILL;
                  base_tag_q <= req_tag;
                  base_idx_q <= req_idx;
                  cnt_q      <= '0;
                  MemReq_q   <= 1'b1;
                  MemAddr_q  <= {req_tag, req_idx, {OFFW{1'b0}}, 2'b00};
               end
            end
            REFILL: begin
               if (MemAck) begin
                  if (last_word) begin
                     state_q  <= IDLE;
                     cnt_q    <= '0;
                     MemReq_q <= 1'b0;
                  end else begin
                     cnt_q     <= cnt_q + OFFW'(1);
                     MemAddr_q <= MemAddr_q + dataW'(4);
                  end
               end
            end
         endcase
      end
   end

   // Capture refill words and the tag of the completed line.
   always_ff @(posedge clock) begin
      if (state_q == REFILL && MemAck) begin
         data_q[base_idx_q][cnt_q] <= MemData;
         if (last_word) tag_q[base_idx_q] <= base_tag_q;
      end
   end

   // Instruction is only served from a hit while idle; otherwise the core sees a NOP.
   always_comb begin
      Instruction = NOP;
      if (state_q == IDLE && hit) Instruction = data_q[req_idx][req_off];
   end

   assign InsCacheStall = (state_q == REFILL) || !hit;
   assign MemReq        = MemReq_q;
   assign MemAddr       = MemAddr_q;

endmodule

// File: doc/ins_cache_r32i.md
Name: ins_cache_r32i

Overview:
Direct-mapped, read-only instruction cache between the RV32I PC and the instruction memory port. It takes ProgAddr from the PC and returns the 32-bit instruction word. On a miss it asserts InsCacheStall, which freezes the PC. It then refills one cache line from memory through a req/ack handshake and releases the stall when the line is valid.

Parameters:
dataW, 32, instruction/data word width and address width.
lineWords, 4, 32-bit words per cache line (power of 2, ≥2).
numLines, 8, number of cache lines (power of 2, ≥2).

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
ProgAddr  input  dataW  byte address from PC; held stable by PC while InsCacheStall=1.
Flush  input  1  invalidate all lines (fence.i); sampled on clock edge.
Instruction  output  dataW  instruction at ProgAddr; valid when InsCacheStall=0.
InsCacheStall  output  1  high while the requested word is not available.
MemReq  output  1  memory read request.
MemAddr  output  dataW  word-aligned byte address of the requested word.
MemAck  input  1  memory has MemData valid for the current MemAddr this cycle.
MemData  input  dataW  read data from memory.

Behaviour:
- Address split:
  - ProgAddr[1:0] ignored.
  - offset = ProgAddr[log2(lineWords)+1:2].
  - index = next log2(numLines) bits.
  - tag = remaining upper bits.
- Storage: per line, one valid bit, one tag, and lineWords data words. Valid bits are cleared on reset; data and tag are not reset.
- Hit: valid[index] && tag match. Combinational from ProgAddr, no added latency.
- Outputs in IDLE:
  - InsCacheStall = !hit.
  - Instruction = hit ? data[index][offset] : 0x00000013 (NOP).
- FSM states: IDLE, REFILL.
- IDLE:
  - On a clock edge with a miss and Flush=0: latch line base = {tag, index, 0s}, word counter = 0, go to REFILL.
  - On a hit: stay in IDLE.
- REFILL:
  - MemReq=1, MemAddr = line base + 4*counter, InsCacheStall=1, Instruction=NOP.
  - On an edge with MemAck=1: write MemData to data[index][counter] and increment the counter.
  - When the last word (counter = lineWords-1) is acked: write the tag, set valid[index], go to IDLE. The next cycle hits with no further stall.
  - With MemAck=0: hold MemReq and MemAddr stable indefinitely. There is no timeout.
  - Consecutive acks in back-to-back cycles are legal; MemAddr advances in the same cycle as the counter.
- Refill memory cost: exactly lineWords acks per miss. Minimum stall on a miss is lineWords+1 cycles (the miss-detect cycle plus lineWords ack cycles).
- Flush:
  - In IDLE: clears all valid bits at the edge, and no refill starts that edge.
  - In REFILL: clears all other valid bits. The in-flight refill completes and its line becomes valid.
- Address stability: a ProgAddr change during REFILL is a protocol violation by the PC. The refill continues with the latched base address.
- Reset (any time, including mid-refill), asynchronous:
  - state = IDLE, MemReq = 0, MemAddr = 0, counter = 0, all valid bits = 0.
  - InsCacheStall then reflects a miss (1) and Instruction = NOP.
- Word order: refill is always sequential from line word 0. There is no critical-word-first.

Test Plan:
1. Cold miss: reset, ProgAddr=0x10, MemAck tied high with MemData = 0xA0+addr.
   - Stall high immediately.
   - MemAddr sequence 0x10, 0x14, 0x18, 0x1C on consecutive cycles.
   - Stall low after 5 cycles; Instruction=0xB0.
2. Same-line hit: after test 1, ProgAddr 0x14 then 0x1C.
   - No stall; Instruction 0xB4 then 0xBC.
   - MemReq stays 0.
3. Conflict eviction: ProgAddr=0x90 (same index as 0x10).
   - Refill of 0x90–0x9C.
   - Returning to 0x10 misses again and refills 0x10–0x1C.
4. Slow memory: MemAck asserted only every 3rd cycle.
   - MemReq/MemAddr held stable between acks.
   - Exactly 4 words written.
   - Stall released one cycle after the 4th ack.
5. Flush: lines 0x10 and 0x20 valid, pulse Flush in IDLE.
   - Both subsequent accesses miss.
   - Flush during an in-flight refill of 0x30 leaves 0x30 valid afterward.
6. Reset mid-refill: assert reset after the 2nd ack of a refill.
   - MemReq drops without a clock edge.
   - After release, ProgAddr=0x10 misses and restarts the refill at 0x10.
